// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : RV32I decode stage
//
// Decodes the instruction held in IF/ID, reads operands from the 32x32
// register file (written by WB, with same-cycle write-through), builds the
// immediate and EX/MEM/WB control, detects load-use hazards and registers
// everything into the ID/EX pipeline register.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   pc_d_i, inst_d_i, pc4_d_i  IF/ID contents (inst 0 = bubble)
//   enable_i, flush_i          ID/EX update enable, bubble request from EX
//   wb_we_i, wb_rd_i, wb_data_i  register-file write port
//   stall_o                    load-use hazard, holds IF and IF/ID
//   *_e_o                      registered ID/EX outputs
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [31:0]     inst_d_i,
  input  logic [XLEN-1:0] pc4_d_i,
  input  logic            enable_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            stall_o,
  output logic [XLEN-1:0] pc_e_o,
  output logic [XLEN-1:0] pc4_e_o,
  output logic [XLEN-1:0] rs1_data_e_o,
  output logic [XLEN-1:0] rs2_data_e_o,
  output logic [XLEN-1:0] imm_e_o,
  output logic [4:0]      rs1_e_o,
  output logic [4:0]      rs2_e_o,
  output logic [4:0]      rd_e_o,
  output logic [3:0]      alu_op_e_o,
  output logic            op_a_sel_e_o,
  output logic            op_b_sel_e_o,
  output logic            br_e_o,
  output logic            jmp_e_o,
  output logic            mem_re_e_o,
  output logic            mem_we_e_o,
  output logic [2:0]      funct3_e_o,
  output logic [1:0]      wb_sel_e_o,
  output logic            rd_we_e_o,
  output logic            illegal_e_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            op_a_sel;
    logic            op_b_sel;
    logic            br;
    logic            jmp;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      funct3;
    logic [1:0]      wb_sel;
    logic            rd_we;
    logic            illegal;
  } idex_t;

  // alt selects SUB (OP only) or SRA; caller qualifies it per opcode
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------- register file ----------------
  logic [XLEN-1:0] rf_q [REG_NUM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [4:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_rd, rs2_rd;

  assign opcode  = inst_d_i[6:0];
  assign rd_idx  = inst_d_i[11:7];
  assign f3      = inst_d_i[14:12];
  assign rs1_idx = inst_d_i[19:15];
  assign rs2_idx = inst_d_i[24:20];

  // write-through so WB and ID can share a cycle without a stale read
  assign rs1_rd = (rs1_idx == 5'd0) ? '0 :
                  (wb_we_i && wb_rd_i == rs1_idx) ? wb_data_i : rf_q[rs1_idx];
  assign rs2_rd = (rs2_idx == 5'd0) ? '0 :
                  (wb_we_i && wb_rd_i == rs2_idx) ? wb_data_i : rf_q[rs2_idx];

  // ---------------- decode ----------------
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst_d_i[31]}}, inst_d_i[31:20]};
  assign imm_s = {{20{inst_d_i[31]}}, inst_d_i[31:25], inst_d_i[11:7]};
  assign imm_b = {{19{inst_d_i[31]}}, inst_d_i[31], inst_d_i[7], inst_d_i[30:25], inst_d_i[11:8], 1'b0};
  assign imm_u = {inst_d_i[31:12], 12'h000};
  assign imm_j = {{11{inst_d_i[31]}}, inst_d_i[31], inst_d_i[19:12], inst_d_i[20], inst_d_i[30:21], 1'b0};

  logic rs1_used, rs2_used, rd_used;
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d     = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    rd_used    = 1'b0;
    idex_d.pc  = pc_d_i;
    idex_d.pc4 = pc4_d_i;
    case (opcode)
      OPC_LUI: begin
        idex_d.imm      = imm_u;
        idex_d.alu_op   = ALU_PASSB;
        idex_d.op_b_sel = 1'b1;
        rd_used         = 1'b1;
      end
      OPC_AUIPC: begin
        idex_d.imm      = imm_u;
        idex_d.op_a_sel = 1'b1;
        idex_d.op_b_sel = 1'b1;
        rd_used         = 1'b1;
      end
      OPC_JAL: begin
        idex_d.imm      = imm_j;
        idex_d.op_a_sel = 1'b1;
        idex_d.op_b_sel = 1'b1;
        idex_d.jmp      = 1'b1;
        idex_d.wb_sel   = WB_PC4;
        rd_used         = 1'b1;
      end
      OPC_JALR: begin
        idex_d.imm      = imm_i;
        idex_d.op_b_sel = 1'b1;
        idex_d.jmp      = 1'b1;
        idex_d.wb_sel   = WB_PC4;
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rd_used         = 1'b1;
      end
      OPC_BRANCH: begin
        // ALU forms the target (PC + imm); comparison uses funct3 in EX
        idex_d.imm      = imm_b;
        idex_d.op_a_sel = 1'b1;
        idex_d.op_b_sel = 1'b1;
        idex_d.br       = 1'b1;
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
      end
      OPC_LOAD: begin
        idex_d.imm      = imm_i;
        idex_d.op_b_sel = 1'b1;
        idex_d.mem_re   = 1'b1;
        idex_d.wb_sel   = WB_MEM;
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rd_used         = 1'b1;
      end
      OPC_STORE: begin
        idex_d.imm      = imm_s;
        idex_d.op_b_sel = 1'b1;
        idex_d.mem_we   = 1'b1;
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
      end
      OPC_OPIMM: begin
        idex_d.imm      = imm_i;
        idex_d.op_b_sel = 1'b1;
        idex_d.alu_op   = alu_from_f3(f3, (f3 == 3'b101) && inst_d_i[30]);
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rd_used         = 1'b1;
      end
      OPC_OP: begin
        idex_d.alu_op   = alu_from_f3(f3, inst_d_i[30]);
        idex_d.funct3   = f3;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        rd_used         = 1'b1;
      end
      default: begin
        // all-zero word is the IF bubble, not an illegal instruction
        idex_d.illegal  = |inst_d_i;
      end
    endcase
    if (rs1_used) begin
      idex_d.rs1      = rs1_idx;
      idex_d.rs1_data = rs1_rd;
    end
    if (rs2_used) begin
      idex_d.rs2      = rs2_idx;
      idex_d.rs2_data = rs2_rd;
    end
    if (rd_used) begin
      idex_d.rd    = rd_idx;
      idex_d.rd_we = (rd_idx != 5'd0);
    end
  end

  // load in EX whose result is needed by the instruction in ID
  assign stall_o = idex_q.mem_re && (idex_q.rd != 5'd0) &&
                   ((rs1_used && idex_q.rd == rs1_idx) ||
                    (rs2_used && idex_q.rd == rs2_idx));

  // ---------------- ID/EX register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idex_q <= '0;
    end else if (enable_i) begin
      if (flush_i || stall_o) idex_q <= '0;
      else                    idex_q <= idex_d;
    end
  end

  assign pc_e_o       = idex_q.pc;
  assign pc4_e_o      = idex_q.pc4;
  assign rs1_data_e_o = idex_q.rs1_data;
  assign rs2_data_e_o = idex_q.rs2_data;
  assign imm_e_o      = idex_q.imm;
  assign rs1_e_o      = idex_q.rs1;
  assign rs2_e_o      = idex_q.rs2;
  assign rd_e_o       = idex_q.rd;
  assign alu_op_e_o   = idex_q.alu_op;
  assign op_a_sel_e_o = idex_q.op_a_sel;
  assign op_b_sel_e_o = idex_q.op_b_sel;
  assign br_e_o       = idex_q.br;
  assign jmp_e_o      = idex_q.jmp;
  assign mem_re_e_o   = idex_q.mem_re;
  assign mem_we_e_o   = idex_q.mem_we;
  assign funct3_e_o   = idex_q.funct3;
  assign wb_sel_e_o   = idex_q.wb_sel;
  assign rd_we_e_o    = idex_q.rd_we;
  assign illegal_e_o  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_d_i, inst_d_i, pc4_d_i;
  logic        enable_i, flush_i, wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic [31:0] pc_e_o, pc4_e_o, rs1_data_e_o, rs2_data_e_o, imm_e_o;
  logic [4:0]  rs1_e_o, rs2_e_o, rd_e_o;
  logic [3:0]  alu_op_e_o;
  logic        op_a_sel_e_o, op_b_sel_e_o, br_e_o, jmp_e_o, mem_re_e_o, mem_we_e_o;
  logic [2:0]  funct3_e_o;
  logic [1:0]  wb_sel_e_o;
  logic        rd_we_e_o, illegal_e_o;

  id_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_d_i(pc_d_i), .inst_d_i(inst_d_i), .pc4_d_i(pc4_d_i),
    .enable_i(enable_i), .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .stall_o(stall_o), .pc_e_o(pc_e_o), .pc4_e_o(pc4_e_o),
    .rs1_data_e_o(rs1_data_e_o), .rs2_data_e_o(rs2_data_e_o), .imm_e_o(imm_e_o),
    .rs1_e_o(rs1_e_o), .rs2_e_o(rs2_e_o), .rd_e_o(rd_e_o), .alu_op_e_o(alu_op_e_o),
    .op_a_sel_e_o(op_a_sel_e_o), .op_b_sel_e_o(op_b_sel_e_o), .br_e_o(br_e_o),
    .jmp_e_o(jmp_e_o), .mem_re_e_o(mem_re_e_o), .mem_we_e_o(mem_we_e_o),
    .funct3_e_o(funct3_e_o), .wb_sel_e_o(wb_sel_e_o), .rd_we_e_o(rd_we_e_o),
    .illegal_e_o(illegal_e_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        opa, opb, br, jmp, mre, mwe;
    logic [2:0]  f3;
    logic [1:0]  wbsel;
    logic        rdwe, ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".pc"},    pc_e_o,       e.pc);
    chk({tag, ".pc4"},   pc4_e_o,      e.pc4);
    chk({tag, ".rs1d"},  rs1_data_e_o, e.rs1d);
    chk({tag, ".rs2d"},  rs2_data_e_o, e.rs2d);
    chk({tag, ".imm"},   imm_e_o,      e.imm);
    chk({tag, ".rs1"},   32'(rs1_e_o), 32'(e.rs1));
    chk({tag, ".rs2"},   32'(rs2_e_o), 32'(e.rs2));
    chk({tag, ".rd"},    32'(rd_e_o),  32'(e.rd));
    chk({tag, ".alu"},   32'(alu_op_e_o), 32'(e.alu));
    chk({tag, ".opa"},   32'(op_a_sel_e_o), 32'(e.opa));
    chk({tag, ".opb"},   32'(op_b_sel_e_o), 32'(e.opb));
    chk({tag, ".br"},    32'(br_e_o),  32'(e.br));
    chk({tag, ".jmp"},   32'(jmp_e_o), 32'(e.jmp));
    chk({tag, ".mre"},   32'(mem_re_e_o), 32'(e.mre));
    chk({tag, ".mwe"},   32'(mem_we_e_o), 32'(e.mwe));
    chk({tag, ".f3"},    32'(funct3_e_o), 32'(e.f3));
    chk({tag, ".wbsel"}, 32'(wb_sel_e_o), 32'(e.wbsel));
    chk({tag, ".rdwe"},  32'(rd_we_e_o), 32'(e.rdwe));
    chk({tag, ".ill"},   32'(illegal_e_o), 32'(e.ill));
  endtask

  function automatic exp_t at_pc(input logic [31:0] pc);
    exp_t e = '0;
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    return e;
  endfunction

  // instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // drive one ID cycle, queue the expected ID/EX contents, compare after the edge
  task automatic apply(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic en, input logic fl, input exp_t e);
    pc_d_i   = pc;
    pc4_d_i  = pc + 32'd4;
    inst_d_i = inst;
    enable_i = en;
    flush_i  = fl;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    wb_we_i = 1'b0;
    if (sb_q.size() == 0) chk({tag, ".sbempty"}, 32'd1, 32'd0);
    else cmp_all(tag, sb_q.pop_front());
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_we_i   = 1'b1;
    wb_rd_i   = rd;
    wb_data_i = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e, e_prev;
    logic [31:0] pc;
    logic [31:0] i_addi8, i_add9;
    rst_ni = 1'b0; pc_d_i = '0; inst_d_i = '0; pc4_d_i = '0;
    enable_i = 1'b1; flush_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    #12;
    cmp_all("reset", '0);
    chk("reset.stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pc = 32'h1000;

    // write-through bypass: x5 written by WB while add x6,x5,x0 in ID
    wb(5'd5, 32'hDEADBEEF);
    e = at_pc(pc); e.rs1d = 32'hDEADBEEF; e.rs1 = 5; e.rd = 6; e.rdwe = 1;
    apply("bypass", pc, enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6), 1, 0, e); pc += 4;

    // x0 write ignored, same-cycle and later
    wb(5'd0, 32'h1234);
    e = at_pc(pc); e.rd = 10; e.rdwe = 1;
    apply("x0_same", pc, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd10), 1, 0, e); pc += 4;
    e = at_pc(pc); e.rd = 10; e.rdwe = 1;
    apply("x0_later", pc, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd10), 1, 0, e); pc += 4;

    // addi x1,x0,-1
    e = at_pc(pc); e.imm = 32'hFFFFFFFF; e.opb = 1; e.rd = 1; e.rdwe = 1;
    apply("addi_m1", pc, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 1, 0, e); pc += 4;

    // lw x7,0(x1) with x1=0x100 arriving from WB in the same cycle
    wb(5'd1, 32'h100);
    pc_d_i = pc; inst_d_i = enc_i(12'h000, 5'd1, 3'd2, 5'd7, 7'h03); #1;
    chk("lw.stall", 32'(stall_o), 32'd0);
    e = at_pc(pc); e.rs1 = 1; e.rs1d = 32'h100; e.rd = 7; e.opb = 1; e.mre = 1;
    e.f3 = 2; e.wbsel = 1; e.rdwe = 1;
    apply("lw", pc, enc_i(12'h000, 5'd1, 3'd2, 5'd7, 7'h03), 1, 0, e); pc += 4;

    // addi x8,x7,1 : load-use -> one bubble, then captured
    i_addi8 = enc_i(12'h001, 5'd7, 3'd0, 5'd8, 7'h13);
    inst_d_i = i_addi8; #1;
    chk("lu.stall1", 32'(stall_o), 32'd1);
    apply("lu.bubble", pc, i_addi8, 1, 0, '0);
    chk("lu.stall2", 32'(stall_o), 32'd0);
    e = at_pc(pc); e.rs1 = 7; e.imm = 1; e.opb = 1; e.rd = 8; e.rdwe = 1;
    apply("lu.addi", pc, i_addi8, 1, 0, e); pc += 4;

    // jal x1,-4
    e = at_pc(pc); e.imm = 32'hFFFFFFFC; e.opa = 1; e.opb = 1; e.jmp = 1; e.wbsel = 2;
    e.rd = 1; e.rdwe = 1;
    apply("jal", pc, enc_j(21'h1FFFFC, 5'd1), 1, 0, e); pc += 4;

    // flush with a valid instruction -> bubble
    apply("flush", pc, enc_r(7'h20, 5'd1, 5'd5, 3'd0, 5'd11), 1, 1, '0); pc += 4;

    // sub x11,x5,x1
    e = at_pc(pc); e.alu = 1; e.rs1 = 5; e.rs1d = 32'hDEADBEEF; e.rs2 = 1; e.rs2d = 32'h100;
    e.rd = 11; e.rdwe = 1;
    apply("sub", pc, enc_r(7'h20, 5'd1, 5'd5, 3'd0, 5'd11), 1, 0, e); pc += 4;
    e_prev = e;

    // enable low -> hold
    apply("hold", pc, {20'h12345, 5'd13, 7'b0110111}, 0, 0, e_prev);

    // lui x13,0x12345
    e = at_pc(pc); e.imm = 32'h12345000; e.alu = 10; e.opb = 1; e.rd = 13; e.rdwe = 1;
    apply("lui", pc, {20'h12345, 5'd13, 7'b0110111}, 1, 0, e); pc += 4;

    // srai x12,x5,3
    e = at_pc(pc); e.imm = 32'h403; e.alu = 7; e.opb = 1; e.rs1 = 5; e.rs1d = 32'hDEADBEEF;
    e.f3 = 5; e.rd = 12; e.rdwe = 1;
    apply("srai", pc, enc_i(12'h403, 5'd5, 3'd5, 5'd12, 7'h13), 1, 0, e); pc += 4;

    // sw x5,8(x1)
    e = at_pc(pc); e.imm = 8; e.opb = 1; e.mwe = 1; e.f3 = 2; e.rs1 = 1; e.rs1d = 32'h100;
    e.rs2 = 5; e.rs2d = 32'hDEADBEEF;
    apply("sw", pc, enc_s(12'd8, 5'd5, 5'd1, 3'd2), 1, 0, e); pc += 4;

    // beq x5,x1,-8
    e = at_pc(pc); e.imm = 32'hFFFFFFF8; e.opa = 1; e.opb = 1; e.br = 1; e.rs1 = 5;
    e.rs1d = 32'hDEADBEEF; e.rs2 = 1; e.rs2d = 32'h100;
    apply("beq", pc, enc_b(13'h1FF8, 5'd1, 5'd5, 3'd0), 1, 0, e); pc += 4;

    // illegal opcode, then IF bubble
    e = at_pc(pc); e.ill = 1;
    apply("illegal", pc, 32'h000001FF, 1, 0, e); pc += 4;
    e = at_pc(pc);
    apply("nop", pc, 32'h0, 1, 0, e); pc += 4;

    // load-use through rs2 coinciding with flush -> single bubble
    e = at_pc(pc); e.rs1 = 1; e.rs1d = 32'h100; e.rd = 7; e.opb = 1; e.mre = 1;
    e.f3 = 2; e.wbsel = 1; e.rdwe = 1;
    apply("lw2", pc, enc_i(12'h000, 5'd1, 3'd2, 5'd7, 7'h03), 1, 0, e); pc += 4;
    i_add9 = enc_r(7'h00, 5'd7, 5'd0, 3'd0, 5'd9);
    inst_d_i = i_add9; #1;
    chk("lu2.stall1", 32'(stall_o), 32'd1);
    apply("lu2.bubble", pc, i_add9, 1, 1, '0);
    chk("lu2.stall2", 32'(stall_o), 32'd0);
    e = at_pc(pc); e.rs2 = 7; e.rd = 9; e.rdwe = 1;
    apply("lu2.add", pc, i_add9, 1, 0, e); pc += 4;

    // addi x0,x0,5 -> rd_we forced low
    e = at_pc(pc); e.imm = 5; e.opb = 1;
    apply("rd0", pc, enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'h13), 1, 0, e); pc += 4;

    // async reset mid-run
    #2 rst_ni = 1'b0;
    #1;
    cmp_all("rst_mid", '0);
    chk("rst_mid.stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // register file cleared: x5 now reads 0
    e = at_pc(pc); e.rs1 = 5; e.rd = 6; e.rdwe = 1;
    apply("rf_cleared", pc, enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6), 1, 0, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
